// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks a 6-bit PC through a synchronous-read
// instruction memory and presents each word to a valid/ready consumer.
module fetch_sequencer #(
  parameter logic [5:0]  RESET_PC = 6'd0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt,
  input  logic             redirect_valid,
  input  logic [5:0]       redirect_addr,
  output logic [5:0]       imem_addr,
  input  logic [31:0]      imem_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr_data,
  output logic [5:0]       instr_pc,
  output logic             busy,
  output logic [CNT_W-1:0] fetch_count
);

  localparam int unsigned PC_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State register; reset dominates every other input in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, memory address and handshake logic
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    imem_addr   = RESET_PC;
    instr_valid = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        // A redirect squashes the word currently presented
        instr_valid = !redirect_valid;
        if (halt) begin
          imem_addr = RESET_PC;
          state_d   = ST_HALT;
        end else if (redirect_valid) begin
          imem_addr = redirect_addr;
        end else if (instr_ready) begin
          imem_addr = PC_W'(pc_q + PC_W'(1));
        end else begin
          imem_addr = pc_q;
        end
        if (!halt) begin
          pc_d = imem_addr;
        end
        if (instr_valid && instr_ready) begin
          cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
      end
      default: begin
        // IDLE and HALT: memory already addressed at RESET_PC, so data is ready next cycle
        if (start) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end
      end
    endcase
  end

  assign instr_data  = imem_data;
  assign instr_pc    = pc_q;
  assign busy        = (state_q == ST_RUN);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural synchronous-read memory.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, halt, redirect_valid, instr_ready;
  logic [5:0]  redirect_addr, imem_addr, instr_pc;
  logic [31:0] imem_data, instr_data;
  logic        instr_valid, busy;
  logic [15:0] fetch_count;

  logic [31:0] mem [64];
  int vecs = 0;
  int errs = 0;

  fetch_sequencer #(.RESET_PC(6'd0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .busy(busy), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= mem[imem_addr];

  function automatic logic [31:0] word_at(input int a);
    return 32'hC0DE_0000 + 32'(a * 257 + 3);
  endfunction

  // Advance one cycle; inputs change 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, start, then accept words until the presented pc equals target
  task automatic go_to(input int target);
    rst = 1'b1; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b1;
    step();
    rst = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (target) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    redirect_addr = 6'd0; instr_ready = 1'b0;
    step(); step();
    rst = 1'b0; #1;
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vecs++; if (imem_addr !== 6'd0) begin errs++; $display("FAIL reset_addr got %0d want 0", imem_addr); end
    vecs++; if (fetch_count !== 16'd0) begin errs++; $display("FAIL reset_count got %0d want 0", fetch_count); end
    // halt/redirect ignored in IDLE
    halt = 1'b1; redirect_valid = 1'b1; redirect_addr = 6'd33; #1;
    vecs++; if (imem_addr !== 6'd0) begin errs++; $display("FAIL idle_addr got %0d want 0", imem_addr); end
    halt = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic test_sequential();
    go_to(0);
    for (int k = 0; k < 4; k++) begin
      vecs++; if (instr_valid !== 1'b1 || instr_pc !== 6'(k) || instr_data !== word_at(k)) begin
        errs++; $display("FAIL seq_%0d got v=%b pc=%0d d=%h want v=1 pc=%0d d=%h",
                         k, instr_valid, instr_pc, instr_data, k, word_at(k));
      end
      step();
    end
    vecs++; if (fetch_count !== 16'd4) begin errs++; $display("FAIL seq_count got %0d want 4", fetch_count); end
  endtask

  task automatic test_stall();
    step();  // pc 4 accepted, now at pc 5
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vecs++; if (instr_pc !== 6'd5 || instr_data !== word_at(5) || fetch_count !== 16'd5) begin
        errs++; $display("FAIL stall_%0d got pc=%0d d=%h cnt=%0d want pc=5 d=%h cnt=5",
                         k, instr_pc, instr_data, fetch_count, word_at(5));
      end
      step();
    end
    instr_ready = 1'b1;
    step();
    vecs++; if (instr_pc !== 6'd6 || fetch_count !== 16'd6) begin
      errs++; $display("FAIL stall_release got pc=%0d cnt=%0d want pc=6 cnt=6", instr_pc, fetch_count);
    end
  endtask

  task automatic test_start_in_run();
    start = 1'b1;
    step();
    start = 1'b0;
    vecs++; if (instr_pc !== 6'd7 || busy !== 1'b1) begin
      errs++; $display("FAIL start_in_run got pc=%0d busy=%b want pc=7 busy=1", instr_pc, busy);
    end
  endtask

  task automatic test_redirect();
    repeat (3) step();  // pc 10
    redirect_valid = 1'b1; redirect_addr = 6'd40; #1;
    vecs++; if (instr_valid !== 1'b0 || imem_addr !== 6'd40) begin
      errs++; $display("FAIL redir_squash got v=%b addr=%0d want v=0 addr=40", instr_valid, imem_addr);
    end
    step();
    redirect_valid = 1'b0; #1;
    vecs++; if (instr_valid !== 1'b1 || instr_pc !== 6'd40 || instr_data !== word_at(40) || fetch_count !== 16'd10) begin
      errs++; $display("FAIL redir_target got v=%b pc=%0d d=%h cnt=%0d want v=1 pc=40 d=%h cnt=10",
                       instr_valid, instr_pc, instr_data, fetch_count, word_at(40));
    end
    step();
    vecs++; if (instr_pc !== 6'd41 || fetch_count !== 16'd11) begin
      errs++; $display("FAIL redir_next got pc=%0d cnt=%0d want pc=41 cnt=11", instr_pc, fetch_count);
    end
  endtask

  task automatic test_wrap();
    go_to(0);
    for (int k = 0; k < 66; k++) begin
      vecs++; if (instr_valid !== 1'b1 || instr_pc !== 6'(k % 64) || instr_data !== word_at(k % 64)) begin
        errs++; $display("FAIL wrap_%0d got v=%b pc=%0d want v=1 pc=%0d", k, instr_valid, instr_pc, k % 64);
      end
      step();
    end
    vecs++; if (fetch_count !== 16'd66) begin errs++; $display("FAIL wrap_count got %0d want 66", fetch_count); end
  endtask

  task automatic test_halt();
    go_to(7);
    halt = 1'b1; redirect_valid = 1'b1; redirect_addr = 6'd50; #1;
    vecs++; if (instr_valid !== 1'b0 || imem_addr !== 6'd0) begin
      errs++; $display("FAIL halt_redir got v=%b addr=%0d want v=0 addr=0", instr_valid, imem_addr);
    end
    step();
    halt = 1'b0; redirect_valid = 1'b0; #1;
    vecs++; if (busy !== 1'b0 || instr_valid !== 1'b0 || fetch_count !== 16'd7) begin
      errs++; $display("FAIL halt_state got busy=%b v=%b cnt=%0d want busy=0 v=0 cnt=7", busy, instr_valid, fetch_count);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    vecs++; if (instr_pc !== 6'd0 || instr_valid !== 1'b1 || instr_data !== word_at(0) || busy !== 1'b1) begin
      errs++; $display("FAIL halt_restart got pc=%0d v=%b busy=%b want pc=0 v=1 busy=1", instr_pc, instr_valid, busy);
    end
    // halt alone with a handshake: transfer counted
    halt = 1'b1;
    step();
    halt = 1'b0;
    vecs++; if (busy !== 1'b0 || fetch_count !== 16'd8) begin
      errs++; $display("FAIL halt_xfer got busy=%b cnt=%0d want busy=0 cnt=8", busy, fetch_count);
    end
  endtask

  task automatic test_rst_run();
    go_to(20);
    vecs++; if (fetch_count !== 16'd20) begin errs++; $display("FAIL rst_pre got cnt=%0d want 20", fetch_count); end
    rst = 1'b1;
    step();
    rst = 1'b0; #1;
    vecs++; if (instr_valid !== 1'b0 || fetch_count !== 16'd0 || imem_addr !== 6'd0 || busy !== 1'b0) begin
      errs++; $display("FAIL rst_run got v=%b cnt=%0d addr=%0d busy=%b want v=0 cnt=0 addr=0 busy=0",
                       instr_valid, fetch_count, imem_addr, busy);
    end
    step();
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL rst_stay_idle got v=%b want 0", instr_valid); end
    start = 1'b1;
    step();
    start = 1'b0;
    vecs++; if (instr_pc !== 6'd0 || instr_valid !== 1'b1 || instr_data !== word_at(0)) begin
      errs++; $display("FAIL rst_restart got pc=%0d v=%b want pc=0 v=1", instr_pc, instr_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = word_at(i);
    test_reset();
    test_sequential();
    test_stall();
    test_start_in_run();
    test_redirect();
    test_wrap();
    test_halt();
    test_rst_run();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: RESET_PC, default 6'd0, start address of every fetch sequence.
REQ-002 Parameter: CNT_W, default 16, width of fetch_count.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst  input  1  synchronous, active-high reset; sampled only on posedge clk.
REQ-005 Port: start  input  1  pulse; begins sequencing from RESET_PC when in IDLE or HALT.
REQ-006 Port: halt  input  1  level; stops sequencing when sampled in RUN.
REQ-007 Port: redirect_valid  input  1  branch/jump redirect request.
REQ-008 Port: redirect_addr  input  6  redirect target word address.
REQ-009 Port: imem_addr  output  6  combinational address to the synchronous-read instruction memory.
REQ-010 Port: imem_data  input  32  registered memory read data; 1-cycle latency after imem_addr.
REQ-011 Port: instr_valid  output  1  instr_data/instr_pc hold a valid instruction.
REQ-012 Port: instr_ready  input  1  consumer accepts the instruction this cycle.
REQ-013 Port: instr_data  output  32  equals imem_data, passed through.
REQ-014 Port: instr_pc  output  6  address of instr_data (register pc_q).
REQ-015 Port: busy  output  1  high when state is RUN.
REQ-016 Port: fetch_count  output  CNT_W  number of accepted instructions since reset.

Function
REQ-017 The FSM SHALL have exactly three states, IDLE, RUN and HALT, with IDLE as the reset state.
REQ-018 Handshake: transfer occurs on a posedge where instr_valid=1 and instr_ready=1.
REQ-019 IDLE/HALT: instr_valid=0, imem_addr=RESET_PC, redirect_valid and halt ignored.
REQ-020 IDLE/HALT with start=1: next state RUN, pc_q<=RESET_PC; instr_valid=1 in the very next cycle (memory already sampled RESET_PC).
REQ-021 RUN: instr_valid = !redirect_valid; instr_pc = pc_q; instr_data = imem_data.
REQ-022 RUN, imem_addr priority: halt=1 -> RESET_PC; else redirect_valid=1 -> redirect_addr; else instr_ready=1 -> pc_q+1; else pc_q.
REQ-023 RUN, on posedge: pc_q <= imem_addr unless halt=1.
REQ-024 Stall (instr_ready=0, no redirect, no halt): imem_addr=pc_q, so instr_data and instr_pc stay stable until accepted.
REQ-025 pc_q+1 SHALL wrap modulo 64 (6'd63 -> 6'd0) with no flag or stall.
REQ-026 Redirect squashes the current instruction: no transfer and no count that cycle; instr_valid=1 next cycle with instr_pc=redirect_addr.
REQ-027 halt=1 in RUN: next state HALT; a handshake in the same cycle completes and is counted.
REQ-028 halt and redirect_valid together: halt wins, redirect discarded, no transfer (instr_valid=0).
REQ-029 start=1 while in RUN SHALL be ignored.
REQ-030 fetch_count increments by 1 per transfer and wraps at 2^CNT_W-1 -> 0.
REQ-031 busy = (state==RUN), registered-state derived, no combinational input path.

Reset
REQ-032 rst=1 at posedge: state<=IDLE, pc_q<=RESET_PC, fetch_count<=0; outputs then: instr_valid=0, busy=0, imem_addr=RESET_PC.
REQ-033 rst SHALL override start, halt, redirect and handshake in the same cycle; a transfer coinciding with rst is not counted.
REQ-034 rst mid-RUN SHALL abandon the in-flight instruction; sequencing resumes only on a new start.

Verification
REQ-035 Reset then start, instr_ready=1 constant -> instr_pc 0,1,2,3 on consecutive cycles, instr_data = mem[0..3], fetch_count=4 after 4 cycles.
REQ-036 Running at pc 5, instr_ready=0 for 3 cycles -> instr_pc=5 and instr_data=mem[5] held all 3 cycles, fetch_count unchanged; ready=1 -> pc 6 next.
REQ-037 At pc 10, redirect_valid=1 redirect_addr=40 -> instr_valid=0 that cycle, next cycle instr_pc=40, then 41; pc 10 not counted.
REQ-038 Start, ready=1 through pc 63 -> next instr_pc=0, no gap in instr_valid.
REQ-039 halt=1 and redirect_valid=1 with ready=1 at pc 7 -> state HALT, no transfer, busy=0 next cycle; start -> instr_pc=0 next cycle.
REQ-040 rst=1 in RUN at pc 20 with ready=1 -> next cycle instr_valid=0, fetch_count=0, imem_addr=0; start=1 -> instr_pc=0.
